// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one stallable memory, one transaction at a time.
// Two-cycle minimum request-to-done latency; the losing requester stalls, and a hung memory latches err.
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_stall,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ERR} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic       last;
   logic [7:0] cnt;
   logic       if_elig, dm_elig;
   logic       grant_i, grant_d, complete, expire;

   // A requester's own done cycle masks the request it is still holding.
   assign if_elig  = if_req & ~if_done;
   assign dm_elig  = dm_req & ~dm_done;
   assign if_stall = if_req & ~if_done;
   assign dm_stall = dm_req & ~dm_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      complete  = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            // On a tie, the side opposite the last grant wins.
            if (dm_elig && (!if_elig || !last)) begin
               grant_d   = 1'b1;
               state_nxt = BUSY_D;
            end else if (if_elig) begin
               grant_i   = 1'b1;
               state_nxt = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_done) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               expire    = 1'b1;
               state_nxt = ERR;
            end
         end
         default: state_nxt = ERR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last      <= 1'b0;
         cnt       <= '0;
         if_done   <= 1'b0;
         dm_done   <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         mem_req   <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
      end else begin
         mem_req <= 1'b0;
         if_done <= 1'b0;
         dm_done <= 1'b0;
         if (grant_i) begin
            mem_req  <= 1'b1;
            mem_addr <= if_addr;
            mem_wr   <= 1'b0;
            last     <= 1'b0;
            cnt      <= '0;
         end
         if (grant_d) begin
            mem_req   <= 1'b1;
            mem_addr  <= dm_addr;
            mem_wr    <= dm_wr;
            mem_wdata <= dm_wdata;
            last      <= 1'b1;
            cnt       <= '0;
         end
         if (complete) begin
            mem_wr <= 1'b0;
            if (state == BUSY_I) begin
               if_done  <= 1'b1;
               if_rdata <= mem_rdata;
            end else begin
               dm_done <= 1'b1;
               if (!mem_wr) dm_rdata <= mem_rdata;
            end
         end else if (state == BUSY_I || state == BUSY_D) begin
            cnt <= cnt + 8'd1;
         end
         if (expire) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// all compared against a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0, mem_done = 1'b0;
   logic [AW-1:0] if_addr = '0, dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
   logic          if_done, if_stall, dm_done, dm_stall, mem_req, mem_wr, err;
   logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .err(err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: which side owns the memory, how long it has waited, and the
   // values every registered output should show in the coming cycle.
   logic          e_if_done, e_dm_done, e_mem_req, e_mem_wr, e_err;
   logic [DW-1:0] e_if_rdata, e_dm_rdata, e_mem_wdata;
   logic [AW-1:0] e_mem_addr;
   int            owner;       // 0 none, 1 fetch, 2 data
   bit            last_data;
   int            waited, lat;
   int            lat_fix  = -1;
   int            p_req    = 60;
   bit            auto_req = 1'b0;
   bit            fix_rdata = 1'b0;
   int            order[$];

   task automatic model_reset();
      e_if_done = 0; e_dm_done = 0; e_mem_req = 0; e_mem_wr = 0; e_err = 0;
      e_if_rdata = '0; e_dm_rdata = '0; e_mem_wdata = '0; e_mem_addr = '0;
      owner = 0; last_data = 0; waited = 0; lat = 0;
   endtask

   task automatic check_outputs();
      chk("if_done", if_done, e_if_done);
      chk("dm_done", dm_done, e_dm_done);
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("dm_rdata", dm_rdata, e_dm_rdata);
      chk("mem_req", mem_req, e_mem_req);
      chk("mem_wr", mem_wr, e_mem_wr);
      chk("mem_addr", mem_addr, e_mem_addr);
      chk("mem_wdata", mem_wdata, e_mem_wdata);
      chk("err", err, e_err);
   endtask

   task automatic cyc_begin();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drive_reqs();
      if (!if_req || e_if_done) begin
         if_req  = ($urandom_range(99) < p_req);
         if_addr = AW'($urandom);
      end
      if (!dm_req || e_dm_done) begin
         dm_req   = ($urandom_range(99) < p_req);
         dm_wr    = 1'($urandom_range(1));
         dm_addr  = AW'($urandom);
         dm_wdata = DW'($urandom);
      end
   endtask

   // Plays the memory for this cycle, checks the stalls, then advances the model to the next edge.
   task automatic cyc_end();
      bit ei, ed;
      if (!fix_rdata) mem_rdata = DW'($urandom);
      mem_done = (owner != 0) ? (waited == lat) : ($urandom_range(3) == 0);
      #1;
      chk("if_stall", if_stall, if_req && !e_if_done);
      chk("dm_stall", dm_stall, dm_req && !e_dm_done);
      ei = if_req && !e_if_done;
      ed = dm_req && !e_dm_done;
      e_if_done = 0;
      e_dm_done = 0;
      e_mem_req = 0;
      if (e_err) begin
         // stuck until reset
      end else if (owner != 0) begin
         if (mem_done) begin
            if (owner == 1) begin
               e_if_done  = 1;
               e_if_rdata = mem_rdata;
            end else begin
               e_dm_done = 1;
               if (!e_mem_wr) e_dm_rdata = mem_rdata;
            end
            e_mem_wr = 0;
            owner    = 0;
         end else begin
            waited++;
            if (waited == TO) begin
               e_err = 1;
               owner = 0;
            end
         end
      end else if (ed && (!ei || !last_data)) begin
         e_mem_req = 1; e_mem_addr = dm_addr; e_mem_wr = dm_wr; e_mem_wdata = dm_wdata;
         owner = 2; last_data = 1; waited = 0;
         lat = (lat_fix < 0) ? int'($urandom_range(3)) : lat_fix;
      end else if (ei) begin
         e_mem_req = 1; e_mem_addr = if_addr; e_mem_wr = 0;
         owner = 1; last_data = 0; waited = 0;
         lat = (lat_fix < 0) ? int'($urandom_range(3)) : lat_fix;
      end
   endtask

   task automatic step();
      cyc_begin();
      if (auto_req) drive_reqs();
      cyc_end();
   endtask

   // Leaves the bench just after a negedge with reset released, ready for cyc_end.
   task automatic do_reset();
      rst = 1; if_req = 0; dm_req = 0; mem_done = 0;
      repeat (2) @(negedge clk);
      model_reset();
      check_outputs();
      rst = 0;
   endtask

   task automatic run_txn(input string tag, input int bound);
      bit seen = 0;
      for (int c = 0; c < bound && !seen; c++) begin
         cyc_begin();
         if (if_done || dm_done) begin
            seen   = 1;
            if_req = 0;
            dm_req = 0;
         end
         cyc_end();
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      do_reset();

      // fetch only, zero-wait memory
      fix_rdata = 1; mem_rdata = 16'hA5A5; lat_fix = 0;
      if_req = 1; if_addr = 16'h0010;
      cyc_end();
      cyc_begin();
      chk("fetch_memreq_c1", mem_req, 1);
      chk("fetch_addr_c1", mem_addr, 16'h0010);
      cyc_end();
      cyc_begin();
      chk("fetch_done_c2", if_done, 1);
      chk("fetch_rdata", if_rdata, 16'hA5A5);
      if_req = 0;
      cyc_end();
      fix_rdata = 0;

      // data write with a slow memory
      cyc_begin();
      dm_req = 1; dm_wr = 1; dm_addr = 16'h0200; dm_wdata = 16'h1234; lat_fix = 3;
      cyc_end();
      cyc_begin();
      chk("wr_mem_wr", mem_wr, 1);
      chk("wr_mem_addr", mem_addr, 16'h0200);
      chk("wr_mem_wdata", mem_wdata, 16'h1234);
      cyc_end();
      run_txn("wr_done_seen", 12);
      chk("wr_dm_rdata_kept", dm_rdata, 16'h0000);

      // both requesting from reset, each re-requesting immediately
      do_reset();
      lat_fix = 1; order.delete();
      if_req = 1; if_addr = 16'h0100; dm_req = 1; dm_wr = 0; dm_addr = 16'h0300;
      cyc_end();
      for (int c = 0; c < 40 && order.size() < 4; c++) begin
         cyc_begin();
         if (if_done) order.push_back(0);
         if (dm_done) order.push_back(1);
         cyc_end();
      end
      chk("order_len", order.size(), 4);
      for (int i = 0; i < 4 && i < order.size(); i++)
         chk("order_seq", order[i], (i % 2 == 0) ? 1 : 0);

      // hung memory
      do_reset();
      lat_fix = 255;
      if_req = 1; if_addr = 16'h0ABC;
      cyc_end();
      repeat (24) step();
      chk("timeout_err", err, 1);
      chk("timeout_stall", if_stall, 1);
      do_reset();
      chk("err_cleared", err, 0);

      // completion on the last counted cycle
      lat_fix = TO - 1;
      dm_req = 1; dm_wr = 0; dm_addr = 16'h0077;
      cyc_end();
      run_txn("boundary_done_seen", 30);
      repeat (2) step();
      chk("boundary_no_err", err, 0);

      // asynchronous reset in the issue cycle of a data write
      cyc_begin();
      lat_fix = 255;
      dm_req = 1; dm_wr = 1; dm_addr = 16'h0301; dm_wdata = 16'hBEEF;
      cyc_end();
      cyc_begin();
      #2 rst = 1;
      #1;
      chk("arst_mem_req", mem_req, 0);
      chk("arst_mem_wr", mem_wr, 0);
      chk("arst_mem_addr", mem_addr, 0);
      chk("arst_mem_wdata", mem_wdata, 0);
      do_reset();
      lat_fix = 1;
      dm_req = 1; dm_wr = 0; dm_addr = 16'h0044;
      cyc_end();
      run_txn("reissue_done_seen", 10);

      // randomized traffic
      do_reset();
      lat_fix = -1; auto_req = 1; p_req = 60;
      drive_reqs();
      cyc_end();
      repeat (3000) step();
      auto_req = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
